// File: rtl/alm_bank.sv
// Multi-channel 12-hour BCD alarm unit: per-channel ring/snooze/stop sequencing,
// in-place edit buffer with field blinking, alarm LED code and display digits.
//
//  state      | meaning
//  -----------+-------------------------------------------------------------
//  ST_OFF     | channel disabled, no compare
//  ST_ARMED   | enabled, waiting for a time match at second 00
//  ST_RINGING | ringing, ring_cnt counts down seconds to auto-stop
//  ST_SNOOZE  | snoozed, snz_cnt counts down seconds until ringing resumes
module alm_bank #(
    parameter int NUM_ALARMS = 4,
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_MIN = 5,
    parameter int SNOOZE_MAX = 3,
    localparam int CH_W      = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick_1hz,
    input  logic                  blink_clk,
    input  logic [3:0]            cur_sec01,
    input  logic [3:0]            cur_sec10,
    input  logic [3:0]            cur_min01,
    input  logic [3:0]            cur_min10,
    input  logic [3:0]            cur_hou01,
    input  logic [3:0]            cur_hou10,
    input  logic                  cur_ampm,
    input  logic [NUM_ALARMS-1:0] en_sw,
    input  logic [CH_W-1:0]       sel,
    input  logic                  setting_toggle,
    input  logic [1:0]            tap_out,
    input  logic                  button_inc,
    input  logic                  button_set,
    input  logic                  button_snooze,
    input  logic                  button_stop,
    output logic [3:0]            blink_min01,
    output logic [3:0]            blink_min10,
    output logic [3:0]            blink_hou01,
    output logic [3:0]            blink_hou10,
    output logic                  blink_ampm,
    output logic [NUM_ALARMS-1:0] ringing,
    output logic [3:0]            LED_alm
);

    typedef enum logic [1:0] {ST_OFF, ST_ARMED, ST_RINGING, ST_SNOOZE} state_t;

    typedef struct packed {
        logic [3:0] h10;
        logic [3:0] h01;
        logic [3:0] m10;
        logic [3:0] m01;
        logic       pm;
    } tod_t;

    localparam tod_t       TOD_RST  = '{h10: 4'd1, h01: 4'd2, m10: 4'd0, m01: 4'd0, pm: 1'b0};
    localparam logic [7:0] RING_LD  = 8'(RING_SEC);
    localparam logic [9:0] SNZ_LD   = 10'(SNOOZE_MIN * 60);
    localparam logic [3:0] USED_MAX = 4'(SNOOZE_MAX);

    state_t     st       [NUM_ALARMS];
    state_t     st_nxt   [NUM_ALARMS];
    logic [7:0] ring_cnt [NUM_ALARMS];
    logic [7:0] ring_nxt [NUM_ALARMS];
    logic [9:0] snz_cnt  [NUM_ALARMS];
    logic [9:0] snz_nxt  [NUM_ALARMS];
    logic [3:0] snz_used [NUM_ALARMS];
    logic [3:0] used_nxt [NUM_ALARMS];
    tod_t       al_t     [NUM_ALARMS];
    tod_t       al_nxt   [NUM_ALARMS];

    tod_t                  edit_q, edit_nxt, disp;
    logic [CH_W-1:0]       sel_q, sel_eff;
    logic                  setting_q;
    logic                  load, do_set, sec_zero;
    logic [NUM_ALARMS-1:0] set_hit, match, ring_nxt_v, snz_nxt_v;
    logic [3:0]            led_nxt;

    // Out-of-range selections keep the last valid channel in place.
    assign sel_eff  = (int'(sel) < NUM_ALARMS) ? sel : sel_q;
    assign load     = setting_toggle && (!setting_q || (sel_eff != sel_q));
    assign do_set   = setting_toggle && button_set;
    assign sec_zero = (cur_sec01 == 4'd0) && (cur_sec10 == 4'd0);

    always_comb begin
        for (int i = 0; i < NUM_ALARMS; i++) begin
            set_hit[i] = do_set && (sel_eff == CH_W'(i));
            match[i]   = tick_1hz && sec_zero &&
                         (cur_min01 == al_t[i].m01) && (cur_min10 == al_t[i].m10) &&
                         (cur_hou01 == al_t[i].h01) && (cur_hou10 == al_t[i].h10) &&
                         (cur_ampm  == al_t[i].pm);
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_ALARMS; i++) begin
            st_nxt[i]   = st[i];
            ring_nxt[i] = ring_cnt[i];
            snz_nxt[i]  = snz_cnt[i];
            used_nxt[i] = snz_used[i];
            al_nxt[i]   = set_hit[i] ? edit_q : al_t[i];

            if (!en_sw[i]) begin
                st_nxt[i]   = ST_OFF;
                ring_nxt[i] = 8'd0;
                snz_nxt[i]  = 10'd0;
                used_nxt[i] = 4'd0;
            end else if (set_hit[i]) begin
                st_nxt[i]   = ST_ARMED;
                ring_nxt[i] = 8'd0;
                snz_nxt[i]  = 10'd0;
                used_nxt[i] = 4'd0;
            end else if (button_stop && (st[i] == ST_RINGING || st[i] == ST_SNOOZE)) begin
                st_nxt[i]   = ST_ARMED;
                ring_nxt[i] = 8'd0;
                snz_nxt[i]  = 10'd0;
            end else if (button_snooze && st[i] == ST_RINGING) begin
                ring_nxt[i] = 8'd0;
                if (snz_used[i] < USED_MAX) begin
                    st_nxt[i]   = ST_SNOOZE;
                    snz_nxt[i]  = SNZ_LD;
                    used_nxt[i] = snz_used[i] + 4'd1;
                end else begin
                    st_nxt[i] = ST_ARMED;
                end
            end else begin
                case (st[i])
                    ST_OFF: st_nxt[i] = ST_ARMED;
                    ST_ARMED: begin
                        if (match[i]) begin
                            st_nxt[i]   = ST_RINGING;
                            ring_nxt[i] = RING_LD;
                            used_nxt[i] = 4'd0;
                        end
                    end
                    ST_RINGING: begin
                        if (tick_1hz) begin
                            if (ring_cnt[i] <= 8'd1) begin
                                st_nxt[i]   = ST_ARMED;
                                ring_nxt[i] = 8'd0;
                            end else begin
                                ring_nxt[i] = ring_cnt[i] - 8'd1;
                            end
                        end
                    end
                    default: begin
                        if (tick_1hz) begin
                            if (snz_cnt[i] <= 10'd1) begin
                                st_nxt[i]   = ST_RINGING;
                                ring_nxt[i] = RING_LD;
                                snz_nxt[i]  = 10'd0;
                            end else begin
                                snz_nxt[i] = snz_cnt[i] - 10'd1;
                            end
                        end
                    end
                endcase
            end

            ring_nxt_v[i] = (st_nxt[i] == ST_RINGING);
            snz_nxt_v[i]  = (st_nxt[i] == ST_SNOOZE);
        end
    end

    always_comb begin
        edit_nxt = edit_q;
        if (load) begin
            edit_nxt = al_t[sel_eff];
        end else if (setting_toggle && button_inc) begin
            case (tap_out)
                2'd0: begin
                    if (edit_q.m01 == 4'd9) begin
                        edit_nxt.m01 = 4'd0;
                        edit_nxt.m10 = (edit_q.m10 == 4'd5) ? 4'd0 : edit_q.m10 + 4'd1;
                    end else begin
                        edit_nxt.m01 = edit_q.m01 + 4'd1;
                    end
                end
                2'd1: begin
                    if (edit_q.h10 == 4'd1 && edit_q.h01 == 4'd2) begin
                        edit_nxt.h10 = 4'd0;
                        edit_nxt.h01 = 4'd1;
                    end else if (edit_q.h01 == 4'd9) begin
                        edit_nxt.h10 = 4'd1;
                        edit_nxt.h01 = 4'd0;
                    end else begin
                        edit_nxt.h01 = edit_q.h01 + 4'd1;
                    end
                end
                2'd2:    edit_nxt.pm = ~edit_q.pm;
                default: ;
            endcase
        end
    end

    // Display follows next-state values so every output lags its cause by one clk.
    always_comb begin
        disp = setting_toggle ? edit_nxt : al_nxt[sel_eff];
        if (setting_toggle && blink_clk) begin
            case (tap_out)
                2'd0: begin
                    disp.m01 = 4'hF;
                    disp.m10 = 4'hF;
                end
                2'd1: begin
                    disp.h01 = 4'hF;
                    disp.h10 = 4'hF;
                end
                2'd2:    disp.pm = 1'b0;
                default: ;
            endcase
        end
        led_nxt = (|ring_nxt_v) ? 4'd9 : ((|snz_nxt_v) ? 4'd5 : 4'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                st[i]       <= ST_OFF;
                ring_cnt[i] <= 8'd0;
                snz_cnt[i]  <= 10'd0;
                snz_used[i] <= 4'd0;
                al_t[i]     <= TOD_RST;
            end
            edit_q      <= TOD_RST;
            sel_q       <= '0;
            setting_q   <= 1'b0;
            blink_min01 <= TOD_RST.m01;
            blink_min10 <= TOD_RST.m10;
            blink_hou01 <= TOD_RST.h01;
            blink_hou10 <= TOD_RST.h10;
            blink_ampm  <= 1'b0;
            ringing     <= '0;
            LED_alm     <= 4'd0;
        end else begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                st[i]       <= st_nxt[i];
                ring_cnt[i] <= ring_nxt[i];
                snz_cnt[i]  <= snz_nxt[i];
                snz_used[i] <= used_nxt[i];
                al_t[i]     <= al_nxt[i];
            end
            edit_q      <= edit_nxt;
            sel_q       <= sel_eff;
            setting_q   <= setting_toggle;
            blink_min01 <= disp.m01;
            blink_min10 <= disp.m10;
            blink_hou01 <= disp.h01;
            blink_hou10 <= disp.h10;
            blink_ampm  <= disp.pm;
            ringing     <= ring_nxt_v;
            LED_alm     <= led_nxt;
        end
    end

endmodule
